// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: width math and parameter legality.
// Pointer/count widths are log2(depth)+1 so a full FIFO is distinguishable from an empty one.
package fifo_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  // Width of a wrap-bit pointer or an occupancy count.
  function automatic int ptr_w(input int depth);
    return clog2(depth) + 1;
  endfunction

  // Width of a memory address.
  function automatic int addr_w(input int depth);
    return clog2(depth);
  endfunction

  function automatic bit fifo_params_ok(
    input int depth,
    input int psize,
    input int af,
    input int ae
  );
    return is_pow2(depth)
        && (psize == ptr_w(depth))
        && (af >= 1) && (af <= depth)
        && (ae >= 0) && (ae < depth);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for sync_fifo_gen: synchronous write, asynchronous read, no reset.
// Ports: clk, i_we/i_waddr/i_wdata (write port), i_raddr -> o_rdata (comb read port).
module sync_fifo_ram #(
  parameter int D_SIZE  = 16,
  parameter int F_DEPTH = 8,
  parameter int A_W     = 3
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [A_W-1:0]    i_waddr,
  input  logic [D_SIZE-1:0] i_wdata,
  input  logic [A_W-1:0]    i_raddr,
  output logic [D_SIZE-1:0] o_rdata
);

  logic [D_SIZE-1:0] mem_q [F_DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/sync_fifo_gen.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, sticky errors.
// Ports: clk, i_rst (async high), i_w_inc/i_w_data, i_r_inc, i_clr_err -> o_r_data,
//   o_full, o_empty, o_almost_full, o_almost_empty, o_count, o_overflow, o_underflow.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read data.
module sync_fifo_gen
  import fifo_pkg::*;
#(
  parameter int D_SIZE   = 16,
  parameter int F_DEPTH  = 8,
  parameter int P_SIZE   = 4,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_w_inc,
  input  logic [D_SIZE-1:0] i_w_data,
  input  logic              i_r_inc,
  input  logic              i_clr_err,
  output logic [D_SIZE-1:0] o_r_data,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_almost_full,
  output logic              o_almost_empty,
  output logic [P_SIZE-1:0] o_count,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam int A_W = P_SIZE - 1;
  localparam logic [P_SIZE-1:0] DEPTH_C = P_SIZE'(F_DEPTH);
  localparam logic [P_SIZE-1:0] AF_C    = P_SIZE'(AF_LEVEL);
  localparam logic [P_SIZE-1:0] AE_C    = P_SIZE'(AE_LEVEL);

  if (!fifo_params_ok(F_DEPTH, P_SIZE, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
    $error("sync_fifo_gen: illegal F_DEPTH/P_SIZE/AF_LEVEL/AE_LEVEL");
  end

  logic [P_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [P_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [P_SIZE-1:0] count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              wr_en, rd_en;
  logic [D_SIZE-1:0] ram_rdata;

  // Flags decode straight from the registered count.
  assign o_full         = (count_q == DEPTH_C);
  assign o_empty        = (count_q == '0);
  assign o_almost_full  = (count_q >= AF_C);
  assign o_almost_empty = (count_q <= AE_C);
  assign o_count        = count_q;
  assign o_overflow     = ovf_q;
  assign o_underflow    = udf_q;

  always_comb begin
    wr_en    = i_w_inc && !o_full;
    rd_en    = i_r_inc && !o_empty;
    wr_ptr_d = wr_en ? wr_ptr_q + P_SIZE'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + P_SIZE'(1) : rd_ptr_q;
    count_d  = count_q;
    if (wr_en && !rd_en) count_d = count_q + P_SIZE'(1);
    if (rd_en && !wr_en) count_d = count_q - P_SIZE'(1);
    // A new error in the same cycle beats a clear.
    ovf_d = (i_w_inc && o_full)  ? 1'b1 : (i_clr_err ? 1'b0 : ovf_q);
    udf_d = (i_r_inc && o_empty) ? 1'b1 : (i_clr_err ? 1'b0 : udf_q);
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  sync_fifo_ram #(
    .D_SIZE  (D_SIZE),
    .F_DEPTH (F_DEPTH),
    .A_W     (A_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (wr_en),
    .i_waddr (wr_ptr_q[A_W-1:0]),
    .i_wdata (i_w_data),
    .i_raddr (rd_ptr_q[A_W-1:0]),
    .o_rdata (ram_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head word shows through; forced to zero while empty so stale
  // or uninitialised memory never leaks out.
  assign o_r_data = o_empty ? '0 : ram_rdata;
`else
  logic [D_SIZE-1:0] r_data_q, r_data_d;

  always_comb begin
    r_data_d = rd_en ? ram_rdata : r_data_q;
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) r_data_q <= '0;
    else       r_data_q <= r_data_d;
  end

  assign o_r_data = r_data_q;
`endif

endmodule
